cu_edge_data_buffer: RTL and testbench

// - Downstream of the CU graph-algorithm control stage. Reassembles 128B CAPI read lines from two 64B halves plus a response, keyed by tag.
// - Queues completed lines in a FIFO.
// - Serves one edge word per edge_request, and reports occupancy back to the control stage through edge_buffer_status.

---
 rtl/cu_edge_data_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_cu_edge_data_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_edge_data_buffer.sv
// Reassembles 128B read lines from two 64B halves plus a response, queues them and serves edge words.
// Optional statistics counters are enabled by defining CU_EDGE_BUF_STATS_EN.
module cu_edge_data_buffer #(
   parameter int TAG_W      = 8,
   parameter int TAG_IDX_W  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int EDGE_W     = 32,
   parameter int ALFULL_TH  = 2
) (
   input  logic                 clock,
   input  logic                 rstn,
   input  logic                 enabled,
   input  logic                 rd0_valid,
   input  logic [TAG_W-1:0]     rd0_tag,
   input  logic [511:0]         rd0_data,
   input  logic                 rd1_valid,
   input  logic [TAG_W-1:0]     rd1_tag,
   input  logic [511:0]         rd1_data,
   input  logic                 rsp_valid,
   input  logic [TAG_W-1:0]     rsp_tag,
   input  logic                 rsp_done,
   input  logic                 edge_request,
   output logic                 edge_valid,
   output logic [EDGE_W-1:0]    edge_data,
   output logic [TAG_IDX_W:0]   buf_count,
   output logic                 buf_empty,
   output logic                 buf_full,
   output logic                 buf_alfull,
   output logic                 rsp_error
`ifdef CU_EDGE_BUF_STATS_EN
   ,
   output logic [31:0]          stat_lines,
   output logic [31:0]          stat_edges,
   output logic [15:0]          stat_errors
`endif
);
   localparam int LINE_W         = 1024;
   localparam int SLOTS          = 1 << TAG_IDX_W;
   localparam int EDGES_PER_LINE = LINE_W / EDGE_W;
   localparam int PTR_W          = $clog2(FIFO_DEPTH);
   localparam int EIDX_W         = $clog2(EDGES_PER_LINE);
   localparam int CNT_W          = TAG_IDX_W + 1;

   // Inputs are single-cycle valid strobes with no back-pressure; edge_request is a pop
   // strobe honoured only when the FIFO is non-empty, answered by edge_valid one cycle later.
   logic [SLOTS-1:0]  h0_q, h0_d, h1_q, h1_d, rsp_q, rsp_d, ok_q, ok_d;
   logic [LINE_W-1:0] slot_data_q [SLOTS];
   logic [LINE_W-1:0] slot_data_d [SLOTS];
   logic [LINE_W-1:0] fifo_q [FIFO_DEPTH];
   logic [LINE_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [EIDX_W-1:0] edge_idx_q, edge_idx_d;
   logic              edge_valid_q, edge_valid_d;
   logic [EDGE_W-1:0] edge_data_q, edge_data_d;
   logic              rsp_error_q, rsp_error_d;

   logic [SLOTS-1:0]     complete, eligible;
   logic                 sel_found, full_w, push, pop_last;
   logic [TAG_IDX_W-1:0] sel_idx, idx0, idx1, idxr;

   logic unused_tag_bits;
   assign unused_tag_bits = ^{rd0_tag[TAG_W-1:TAG_IDX_W], rd1_tag[TAG_W-1:TAG_IDX_W],
                              rsp_tag[TAG_W-1:TAG_IDX_W]};

   assign idx0 = rd0_tag[TAG_IDX_W-1:0];
   assign idx1 = rd1_tag[TAG_IDX_W-1:0];
   assign idxr = rsp_tag[TAG_IDX_W-1:0];

   // Failed lines need no FIFO space, so they may retire even while the FIFO is full.
   always_comb begin
      full_w    = (count_q == CNT_W'(FIFO_DEPTH));
      complete  = h0_q & h1_q & rsp_q;
      eligible  = complete & (~ok_q | {SLOTS{~full_w}});
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel_found = 1'b1;
            sel_idx   = TAG_IDX_W'(i);
         end
      end
   end

   always_comb begin
      h0_d         = h0_q;
      h1_d         = h1_q;
      rsp_d        = rsp_q;
      ok_d         = ok_q;
      slot_data_d  = slot_data_q;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      edge_idx_d   = edge_idx_q;
      edge_valid_d = 1'b0;
      edge_data_d  = edge_data_q;
      rsp_error_d  = 1'b0;
      push         = 1'b0;
      pop_last     = 1'b0;
      if (enabled) begin
         if (sel_found) begin
            h0_d[sel_idx]  = 1'b0;
            h1_d[sel_idx]  = 1'b0;
            rsp_d[sel_idx] = 1'b0;
            if (ok_q[sel_idx]) begin
               fifo_d[wr_ptr_q] = slot_data_q[sel_idx];
               wr_ptr_d         = wr_ptr_q + PTR_W'(1);
               push             = 1'b1;
            end else begin
               rsp_error_d = 1'b1;
            end
         end
         // New arrivals are applied after the commit clear so a same-cycle hit is kept.
         if (rd0_valid) begin
            h0_d[idx0]               = 1'b1;
            slot_data_d[idx0][511:0] = rd0_data;
         end
         if (rd1_valid) begin
            h1_d[idx1]                  = 1'b1;
            slot_data_d[idx1][1023:512] = rd1_data;
         end
         if (rsp_valid) begin
            rsp_d[idxr] = 1'b1;
            ok_d[idxr]  = rsp_done;
         end
         if (edge_request && (count_q != '0)) begin
            edge_valid_d = 1'b1;
            edge_data_d  = fifo_q[rd_ptr_q][int'(edge_idx_q) * EDGE_W +: EDGE_W];
            if (edge_idx_q == EIDX_W'(EDGES_PER_LINE - 1)) begin
               edge_idx_d = '0;
               rd_ptr_d   = rd_ptr_q + PTR_W'(1);
               pop_last   = 1'b1;
            end else begin
               edge_idx_d = edge_idx_q + EIDX_W'(1);
            end
         end
         case ({push, pop_last})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         h0_q         <= '0;
         h1_q         <= '0;
         rsp_q        <= '0;
         ok_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         edge_idx_q   <= '0;
         edge_valid_q <= 1'b0;
         edge_data_q  <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         h0_q         <= h0_d;
         h1_q         <= h1_d;
         rsp_q        <= rsp_d;
         ok_q         <= ok_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         edge_idx_q   <= edge_idx_d;
         edge_valid_q <= edge_valid_d;
         edge_data_q  <= edge_data_d;
         rsp_error_q  <= rsp_error_d;
      end
   end

   // Line storage is qualified by the flags and pointers, so it carries no reset.
   always_ff @(posedge clock) begin
      slot_data_q <= slot_data_d;
      fifo_q      <= fifo_d;
   end

   assign edge_valid = edge_valid_q;
   assign edge_data  = edge_data_q;
   assign buf_count  = count_q;
   assign buf_empty  = (count_q == '0);
   assign buf_full   = (count_q == CNT_W'(FIFO_DEPTH));
   assign buf_alfull = ((CNT_W'(FIFO_DEPTH) - count_q) <= CNT_W'(ALFULL_TH));
   assign rsp_error  = rsp_error_q;

`ifdef CU_EDGE_BUF_STATS_EN
   logic [31:0] stat_lines_q, stat_lines_d, stat_edges_q, stat_edges_d;
   logic [15:0] stat_errors_q, stat_errors_d;

   always_comb begin
      stat_lines_d  = stat_lines_q + {31'd0, push};
      stat_edges_d  = stat_edges_q + {31'd0, edge_valid_d};
      stat_errors_d = stat_errors_q + {15'd0, rsp_error_d};
   end

   always_ff @(posedge clock) begin
      if (rstn) begin
         stat_lines_q  <= '0;
         stat_edges_q  <= '0;
         stat_errors_q <= '0;
      end else begin
         stat_lines_q  <= stat_lines_d;
         stat_edges_q  <= stat_edges_d;
         stat_errors_q <= stat_errors_d;
      end
   end

   assign stat_lines  = stat_lines_q;
   assign stat_edges  = stat_edges_q;
   assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_cu_edge_data_buffer.sv
// Directed bench for cu_edge_data_buffer: staging, commit order, failed responses, full/alfull,
// concurrent push/retire, reset flush and enable gating.
module tb_cu_edge_data_buffer;
   logic          clock = 1'b0;
   logic          rstn = 1'b1;
   logic          enabled = 1'b0;
   logic          rd0_valid = 1'b0, rd1_valid = 1'b0, rsp_valid = 1'b0;
   logic [7:0]    rd0_tag = '0, rd1_tag = '0, rsp_tag = '0;
   logic [511:0]  rd0_data = '0, rd1_data = '0;
   logic          rsp_done = 1'b0;
   logic          edge_request = 1'b0;
   logic          edge_valid;
   logic [31:0]   edge_data;
   logic [4:0]    buf_count;
   logic          buf_empty, buf_full, buf_alfull, rsp_error;
`ifdef CU_EDGE_BUF_STATS_EN
   logic [31:0]   stat_lines, stat_edges;
   logic [15:0]   stat_errors;
`endif

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   cu_edge_data_buffer dut (
      .clock(clock), .rstn(rstn), .enabled(enabled),
      .rd0_valid(rd0_valid), .rd0_tag(rd0_tag), .rd0_data(rd0_data),
      .rd1_valid(rd1_valid), .rd1_tag(rd1_tag), .rd1_data(rd1_data),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_done(rsp_done),
      .edge_request(edge_request), .edge_valid(edge_valid), .edge_data(edge_data),
      .buf_count(buf_count), .buf_empty(buf_empty), .buf_full(buf_full),
      .buf_alfull(buf_alfull), .rsp_error(rsp_error)
`ifdef CU_EDGE_BUF_STATS_EN
      , .stat_lines(stat_lines), .stat_edges(stat_edges), .stat_errors(stat_errors)
`endif
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // scoreboard helpers
   function automatic logic [31:0] mk_word(input logic [15:0] seed, input int w);
      logic [7:0] wb;
      wb = 8'(w);
      return {seed, 8'hA5 ^ wb, wb};
   endfunction

   function automatic logic [1023:0] mk_line(input logic [15:0] seed);
      logic [1023:0] line;
      for (int w = 0; w < 32; w++) line[w*32 +: 32] = mk_word(seed, w);
      return line;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic stage(input logic v0, input logic [7:0] t0, input logic [15:0] s0,
                        input logic v1, input logic [7:0] t1, input logic [15:0] s1,
                        input logic vr, input logic [7:0] tr, input logic done);
      logic [1023:0] l0, l1;
      l0 = mk_line(s0);
      l1 = mk_line(s1);
      rd0_valid = v0; rd0_tag = t0; rd0_data = l0[511:0];
      rd1_valid = v1; rd1_tag = t1; rd1_data = l1[1023:512];
      rsp_valid = vr; rsp_tag = tr; rsp_done = done;
      step();
      rd0_valid = 1'b0; rd1_valid = 1'b0; rsp_valid = 1'b0;
   endtask

   task automatic stage_line(input logic [7:0] tag, input logic [15:0] seed);
      stage(1'b1, tag, seed, 1'b1, tag, seed, 1'b1, tag, 1'b1);
   endtask

   task automatic pop_words(input logic [15:0] seed, input int first, input int n);
      for (int w = first; w < first + n; w++) begin
         edge_request = 1'b1;
         step();
         check("pop_valid", 64'(edge_valid), 64'd1);
         check("pop_data", 64'(edge_data), 64'(mk_word(seed, w)));
      end
      edge_request = 1'b0;
   endtask

   task automatic pop_line();
      logic [15:0] seed;
      seed = exp_q.pop_front();
      pop_words(seed, 0, 32);
   endtask

   initial begin
      // reset values
      step(); step();
      check("rst_count", 64'(buf_count), 64'd0);
      check("rst_empty", 64'(buf_empty), 64'd1);
      check("rst_full", 64'(buf_full), 64'd0);
      check("rst_alfull", 64'(buf_alfull), 64'd0);
      check("rst_edge_valid", 64'(edge_valid), 64'd0);
      check("rst_edge_data", 64'(edge_data), 64'd0);
      check("rst_rsp_error", 64'(rsp_error), 64'd0);
      rstn = 1'b0;
      enabled = 1'b1;
      step();

      // single line, tag 3, all events in one cycle
      stage_line(8'd3, 16'h0301);
      exp_q.push_back(16'h0301);
      check("t3_count_1cyc", 64'(buf_count), 64'd0);
      step();
      check("t3_count_2cyc", 64'(buf_count), 64'd1);
      check("t3_empty", 64'(buf_empty), 64'd0);
      pop_line();
      check("t3_empty_after", 64'(buf_empty), 64'd1);
      check("t3_count_after", 64'(buf_count), 64'd0);
      edge_request = 1'b1;
      step();
      edge_request = 1'b0;
      check("pop_when_empty", 64'(edge_valid), 64'd0);

      // tags 5 and 2 become ready together; lower index commits first
      stage(1'b1, 8'd5, 16'h0505, 1'b1, 8'd5, 16'h0505, 1'b1, 8'd2, 1'b1);
      stage(1'b1, 8'd2, 16'h0202, 1'b1, 8'd2, 16'h0202, 1'b1, 8'd5, 1'b1);
      exp_q.push_back(16'h0202);
      exp_q.push_back(16'h0505);
      check("two_count0", 64'(buf_count), 64'd0);
      step();
      check("two_count1", 64'(buf_count), 64'd1);
      step();
      check("two_count2", 64'(buf_count), 64'd2);
      pop_line();
      pop_line();
      check("two_empty", 64'(buf_empty), 64'd1);

      // failing response on tag 7, then slot reuse
      stage(1'b1, 8'd7, 16'h0700, 1'b1, 8'd7, 16'h0700, 1'b0, 8'd0, 1'b0);
      stage(1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 16'h0000, 1'b1, 8'd7, 1'b0);
      check("err_not_yet", 64'(rsp_error), 64'd0);
      step();
      check("err_pulse", 64'(rsp_error), 64'd1);
      check("err_count", 64'(buf_count), 64'd0);
      step();
      check("err_pulse_end", 64'(rsp_error), 64'd0);
      check("err_count2", 64'(buf_count), 64'd0);
      stage_line(8'd7, 16'h0777);
      exp_q.push_back(16'h0777);
      step();
      check("reuse_count", 64'(buf_count), 64'd1);
      pop_line();

      // fill to full, ninth line waits for space
      for (int i = 0; i < 8; i++) begin
         stage_line(8'(i), 16'h1000 + 16'(i));
         exp_q.push_back(16'h1000 + 16'(i));
         check("fill_count", 64'(buf_count), 64'(i));
         check("fill_alfull", 64'(buf_alfull), 64'((8 - i) <= 2));
      end
      step();
      check("full_count", 64'(buf_count), 64'd8);
      check("full_flag", 64'(buf_full), 64'd1);
      check("full_alfull", 64'(buf_alfull), 64'd1);
      stage_line(8'd9, 16'h1009);
      exp_q.push_back(16'h1009);
      step(); step();
      check("wait_count", 64'(buf_count), 64'd8);
      pop_line();
      check("after_pop_count", 64'(buf_count), 64'd7);
      check("after_pop_full", 64'(buf_full), 64'd0);
      step();
      check("ninth_commit", 64'(buf_count), 64'd8);
      for (int i = 0; i < 8; i++) pop_line();
      check("drain_empty", 64'(buf_empty), 64'd1);

      // last-word pop concurrent with a push
      stage_line(8'd1, 16'h2001);
      exp_q.push_back(16'h2001);
      step();
      check("cc_count_a", 64'(buf_count), 64'd1);
      pop_words(16'h2001, 0, 31);
      stage_line(8'd4, 16'h2004);
      exp_q.push_back(16'h2004);
      edge_request = 1'b1;
      step();
      edge_request = 1'b0;
      check("cc_last_valid", 64'(edge_valid), 64'd1);
      check("cc_last_data", 64'(edge_data), 64'(mk_word(16'h2001, 31)));
      check("cc_count_b", 64'(buf_count), 64'd1);
      void'(exp_q.pop_front());
      pop_line();
      check("cc_empty", 64'(buf_empty), 64'd1);

      // reset with queued lines and partial staging
      stage_line(8'd10, 16'h300A);
      stage_line(8'd11, 16'h300B);
      stage_line(8'd12, 16'h300C);
      stage(1'b1, 8'd13, 16'h3013, 1'b1, 8'd14, 16'h3014, 1'b0, 8'd0, 1'b0);
      check("pre_rst_count", 64'(buf_count), 64'd3);
      pop_words(16'h300A, 0, 5);
      rstn = 1'b1;
      step();
      rstn = 1'b0;
      check("mid_rst_count", 64'(buf_count), 64'd0);
      check("mid_rst_empty", 64'(buf_empty), 64'd1);
      check("mid_rst_full", 64'(buf_full), 64'd0);
      check("mid_rst_alfull", 64'(buf_alfull), 64'd0);
      check("mid_rst_valid", 64'(edge_valid), 64'd0);
      check("mid_rst_data", 64'(edge_data), 64'd0);
      check("mid_rst_err", 64'(rsp_error), 64'd0);
      edge_request = 1'b1;
      step();
      edge_request = 1'b0;
      check("post_rst_pop", 64'(edge_valid), 64'd0);
      stage(1'b0, 8'd0, 16'h0000, 1'b1, 8'd13, 16'h3013, 1'b1, 8'd13, 1'b1);
      step(); step();
      check("post_rst_no_commit", 64'(buf_count), 64'd0);
      stage(1'b1, 8'd13, 16'h3013, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 1'b0);
      exp_q.push_back(16'h3013);
      step();
      check("post_rst_commit", 64'(buf_count), 64'd1);
      pop_line();

      // enable gating holds state and ignores inputs
      stage_line(8'd6, 16'h3006);
      exp_q.push_back(16'h3006);
      step();
      check("en_count_a", 64'(buf_count), 64'd1);
      enabled = 1'b0;
      edge_request = 1'b1;
      stage_line(8'd8, 16'h3008);
      check("dis_valid", 64'(edge_valid), 64'd0);
      check("dis_count", 64'(buf_count), 64'd1);
      step();
      edge_request = 1'b0;
      enabled = 1'b1;
      step(); step();
      check("en_count_b", 64'(buf_count), 64'd1);
      pop_line();
      check("final_empty", 64'(buf_empty), 64'd1);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      // report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
